// File: rtl/trade_pkg.sv
// Shared types and helpers for the trade order sequencer.
// Holds the FSM state encoding, the order side encoding and saturating-counter helpers.
package trade_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CONFIRM  = 3'd1,
        ISSUE    = 3'd2,
        WAIT_ACK = 3'd3,
        COOLDOWN = 3'd4
    } ctrl_state_t;

    typedef enum logic {
        SIDE_BUY  = 1'b0,
        SIDE_SELL = 1'b1
    } side_t;

    localparam logic [15:0] FILL_MAX = 16'hFFFF;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == FILL_MAX) ? v : v + 16'd1;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/trade_timer.sv
// Loadable, clearable up-counter; raises last when the count equals the supplied limit.
// Priority: reset, clear, load, enable.
module trade_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic [WIDTH-1:0] limit,
    output logic             last
);

    logic [WIDTH-1:0] count_r;

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_r <= {WIDTH{1'b0}};
        end else if (clr) begin
            count_r <= {WIDTH{1'b0}};
        end else if (load) begin
            count_r <= load_val;
        end else if (en) begin
            count_r <= count_r + WIDTH'(1);
        end
    end

    assign last = (count_r == limit);

endmodule

// File: rtl/trade_order_ctrl.sv
// Order sequencer: debounces strategy signals, enforces the position limit and issues one order
// at a time, then waits for an ack (with timeout) and cools down before re-arming.
module trade_order_ctrl
    import trade_pkg::*;
#(
    parameter int CONFIRM_CYCLES  = 2,
    parameter int COOLDOWN_CYCLES = 16,
    parameter int ACK_TIMEOUT     = 64,
    parameter int MAX_POS         = 3,
    localparam int POS_W          = $clog2(MAX_POS + 1) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             kill,
    input  logic             buy_signal,
    input  logic             sell_signal,
    output logic             ord_valid,
    input  logic             ord_ready,
    output logic             ord_side,
    input  logic             ack_valid,
    input  logic             ack_fill,
    output logic [POS_W-1:0] position,
    output logic [15:0]      fill_count,
    output logic             busy,
    output logic             timeout_err
);

    localparam int TMR_W = $clog2(max3(CONFIRM_CYCLES, COOLDOWN_CYCLES, ACK_TIMEOUT) + 1);
    localparam logic signed [POS_W-1:0] POS_MAX = POS_W'(MAX_POS);
    localparam logic signed [POS_W-1:0] POS_MIN = -POS_MAX;

    ctrl_state_t        state_r, next_s;
    side_t              side_r;
    logic               ord_valid_r, busy_r, timeout_err_r;
    logic [POS_W-1:0]   pos_r;
    logic [15:0]        fill_r;

    logic req_buy_s, req_sell_s, buy_ok_s, sell_ok_s, arm_ok_s, start_s, hold_s, hs_s;
    logic t_clr_s, t_load_s, t_en_s, t_last_s;
    logic [TMR_W-1:0] t_limit_s;

    assign req_buy_s  = buy_signal & ~sell_signal;
    assign req_sell_s = sell_signal & ~buy_signal;
    assign buy_ok_s   = req_buy_s & ($signed(pos_r) < POS_MAX);
    assign sell_ok_s  = req_sell_s & ($signed(pos_r) > POS_MIN);
    assign arm_ok_s   = enable & ~kill & ~timeout_err_r;
    assign start_s    = arm_ok_s & (buy_ok_s | sell_ok_s);
    assign hold_s     = arm_ok_s & ((side_r == SIDE_BUY) ? req_buy_s : req_sell_s);
    assign hs_s       = ord_valid_r & ord_ready;

    // Next-state and shared-timer control; the timer is cleared whenever it is not counting.
    always_comb begin
        next_s    = state_r;
        t_en_s    = 1'b0;
        t_load_s  = 1'b0;
        t_limit_s = {TMR_W{1'b0}};
        case (state_r)
            IDLE: begin
                if (start_s) begin
                    if (CONFIRM_CYCLES == 1) begin
                        next_s = ISSUE;
                    end else begin
                        next_s   = CONFIRM;
                        t_load_s = 1'b1;
                    end
                end else begin
                    next_s = IDLE;
                end
            end
            CONFIRM: begin
                t_limit_s = TMR_W'(CONFIRM_CYCLES - 1);
                if (!hold_s) begin
                    next_s = IDLE;
                end else if (t_last_s) begin
                    next_s = ISSUE;
                end else begin
                    t_en_s = 1'b1;
                end
            end
            ISSUE: begin
                if (hs_s) begin
                    next_s = WAIT_ACK;
                end else begin
                    next_s = ISSUE;
                end
            end
            WAIT_ACK: begin
                t_limit_s = TMR_W'(ACK_TIMEOUT - 1);
                if (ack_valid || t_last_s) begin
                    next_s = COOLDOWN;
                end else begin
                    t_en_s = 1'b1;
                end
            end
            COOLDOWN: begin
                t_limit_s = TMR_W'(COOLDOWN_CYCLES - 1);
                if (t_last_s) begin
                    next_s = IDLE;
                end else begin
                    t_en_s = 1'b1;
                end
            end
            default: begin
                next_s = IDLE;
            end
        endcase
        t_clr_s = ~t_en_s & ~t_load_s;
    end

    trade_timer #(.WIDTH(TMR_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clr      (t_clr_s),
        .load     (t_load_s),
        .load_val (TMR_W'(1)),
        .en       (t_en_s),
        .limit    (t_limit_s),
        .last     (t_last_s)
    );

    // FSM state plus all registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r       <= IDLE;
            side_r        <= SIDE_BUY;
            ord_valid_r   <= 1'b0;
            busy_r        <= 1'b0;
            timeout_err_r <= 1'b0;
            pos_r         <= {POS_W{1'b0}};
            fill_r        <= 16'd0;
        end else begin
            state_r <= next_s;
            busy_r  <= (next_s != IDLE);
            case (state_r)
                IDLE: begin
                    if (start_s) begin
                        side_r <= buy_ok_s ? SIDE_BUY : SIDE_SELL;
                    end
                end
                ISSUE: begin
                    // Valid rises one cycle after entry and is only dropped by the handshake.
                    if (!ord_valid_r) begin
                        ord_valid_r <= 1'b1;
                    end else if (ord_ready) begin
                        ord_valid_r <= 1'b0;
                    end
                end
                WAIT_ACK: begin
                    if (ack_valid && ack_fill) begin
                        pos_r  <= (side_r == SIDE_BUY) ? pos_r + POS_W'(1) : pos_r - POS_W'(1);
                        fill_r <= sat_inc16(fill_r);
                    end else if (!ack_valid && t_last_s) begin
                        timeout_err_r <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign ord_valid   = ord_valid_r;
    assign ord_side    = side_r;
    assign position    = pos_r;
    assign fill_count  = fill_r;
    assign busy        = busy_r;
    assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_trade_order_ctrl.sv
// Directed self-checking bench for trade_order_ctrl with default parameters.
module tb_trade_order_ctrl;

    logic        clk = 1'b0;
    logic        rst, enable, kill, buy_signal, sell_signal, ord_ready, ack_valid, ack_fill;
    logic        ord_valid, ord_side, busy, timeout_err;
    logic [2:0]  position;
    logic [15:0] fill_count;
    int          total = 0;
    int          bad   = 0;
    logic        seen;

    trade_order_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .kill        (kill),
        .buy_signal  (buy_signal),
        .sell_signal (sell_signal),
        .ord_valid   (ord_valid),
        .ord_ready   (ord_ready),
        .ord_side    (ord_side),
        .ack_valid   (ack_valid),
        .ack_fill    (ack_fill),
        .position    (position),
        .fill_count  (fill_count),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Arm an order, wait for valid, handshake, ack after ack_delay cycles, wait for idle.
    task automatic do_order(input logic is_sell, input logic fill_it, input int ack_delay);
        buy_signal  = ~is_sell;
        sell_signal = is_sell;
        ord_ready   = 1'b1;
        seen        = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (ord_valid) seen = 1'b1;
        end
        chk("ord_valid_seen", 32'(seen), 32'd1);
        chk("ord_side", 32'(ord_side), 32'(is_sell));
        buy_signal  = 1'b0;
        sell_signal = 1'b0;
        tick();
        chk("valid_drop", 32'(ord_valid), 32'd0);
        ord_ready = 1'b0;
        tick(ack_delay);
        ack_valid = 1'b1;
        ack_fill  = fill_it;
        tick();
        ack_valid = 1'b0;
        ack_fill  = 1'b0;
        seen      = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (!busy) seen = 1'b1;
        end
        chk("back_to_idle", 32'(seen), 32'd1);
    endtask

    initial begin
        rst = 1'b0; enable = 1'b1; kill = 1'b0; buy_signal = 1'b0; sell_signal = 1'b0;
        ord_ready = 1'b0; ack_valid = 1'b0; ack_fill = 1'b0; seen = 1'b0;
        tick(2);
        chk("rst_valid", 32'(ord_valid), 32'd0);
        chk("rst_side", 32'(ord_side), 32'd0);
        chk("rst_pos", 32'(position), 32'd0);
        chk("rst_fill", 32'(fill_count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_terr", 32'(timeout_err), 32'd0);
        rst = 1'b1;
        tick();

        // 1: buy held 3 cycles, ready high, fill after 2 cycles
        buy_signal = 1'b1; ord_ready = 1'b1;
        tick();
        chk("t1_busy_confirm", 32'(busy), 32'd1);
        chk("t1_no_valid_c1", 32'(ord_valid), 32'd0);
        tick();
        chk("t1_no_valid_c2", 32'(ord_valid), 32'd0);
        tick();
        chk("t1_valid_latency", 32'(ord_valid), 32'd1);
        chk("t1_side", 32'(ord_side), 32'd0);
        buy_signal = 1'b0;
        tick();
        chk("t1_one_beat", 32'(ord_valid), 32'd0);
        ord_ready = 1'b0;
        tick();
        ack_valid = 1'b1; ack_fill = 1'b1;
        tick();
        ack_valid = 1'b0; ack_fill = 1'b0;
        chk("t1_pos", 32'(position), 32'd1);
        chk("t1_fill", 32'(fill_count), 32'd1);
        ack_valid = 1'b1; ack_fill = 1'b1;
        tick();
        ack_valid = 1'b0; ack_fill = 1'b0;
        chk("t1_ack_ignored_cooldown", 32'(position), 32'd1);
        tick(14);
        chk("t1_busy_cooldown_end", 32'(busy), 32'd1);
        tick();
        chk("t1_idle_after_cooldown", 32'(busy), 32'd0);

        // 2: single-cycle buy pulse
        buy_signal = 1'b1;
        tick();
        chk("t2_confirm", 32'(busy), 32'd1);
        buy_signal = 1'b0;
        tick();
        chk("t2_abort", 32'(busy), 32'd0);
        tick(3);
        chk("t2_no_valid", 32'(ord_valid), 32'd0);
        chk("t2_pos", 32'(position), 32'd1);

        // 3: buy and sell together are no request
        buy_signal = 1'b1; sell_signal = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t3_busy", 32'(busy), 32'd0);
        end
        buy_signal = 1'b0; sell_signal = 1'b0;

        // 4: reach +3, buy blocked, sell allowed, then a rejected buy
        do_order(1'b0, 1'b1, 1);
        do_order(1'b0, 1'b1, 3);
        chk("t4_pos_max", 32'(position), 32'd3);
        buy_signal = 1'b1;
        tick(10);
        chk("t4_buy_blocked", 32'(busy), 32'd0);
        buy_signal = 1'b0;
        do_order(1'b1, 1'b1, 2);
        chk("t4_pos_after_sell", 32'(position), 32'd2);
        chk("t4_fill", 32'(fill_count), 32'd4);
        do_order(1'b0, 1'b0, 2);
        chk("t4_reject_pos", 32'(position), 32'd2);
        chk("t4_reject_fill", 32'(fill_count), 32'd4);

        // 5: ready held low with kill raised mid-ISSUE
        buy_signal = 1'b1; ord_ready = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (ord_valid) seen = 1'b1;
        end
        chk("t5_valid_seen", 32'(seen), 32'd1);
        buy_signal = 1'b0; kill = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t5_valid_hold", 32'(ord_valid), 32'd1);
            chk("t5_side_hold", 32'(ord_side), 32'd0);
        end
        ord_ready = 1'b1;
        tick();
        chk("t5_valid_drop", 32'(ord_valid), 32'd0);
        ord_ready = 1'b0; ack_valid = 1'b1; ack_fill = 1'b1;
        tick();
        ack_valid = 1'b0; ack_fill = 1'b0;
        chk("t5_pos", 32'(position), 32'd3);
        sell_signal = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (ord_valid) seen = 1'b1;
        end
        chk("t5_no_rearm_valid", 32'(seen), 32'd0);
        chk("t5_no_rearm_busy", 32'(busy), 32'd0);
        sell_signal = 1'b0; kill = 1'b0;
        tick();

        // 6: ack timeout
        sell_signal = 1'b1; ord_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (ord_valid) seen = 1'b1;
        end
        chk("t6_valid_seen", 32'(seen), 32'd1);
        sell_signal = 1'b0;
        tick();
        ord_ready = 1'b0;
        tick(63);
        chk("t6_no_terr_yet", 32'(timeout_err), 32'd0);
        chk("t6_still_waiting", 32'(busy), 32'd1);
        tick();
        chk("t6_terr", 32'(timeout_err), 32'd1);
        chk("t6_pos_unchanged", 32'(position), 32'd3);
        tick(20);
        chk("t6_idle", 32'(busy), 32'd0);
        sell_signal = 1'b1;
        tick(10);
        chk("t6_blocked", 32'(busy), 32'd0);
        chk("t6_fill_before_rst", 32'(fill_count), 32'd5);
        sell_signal = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("t6_rst_terr", 32'(timeout_err), 32'd0);
        chk("t6_rst_pos", 32'(position), 32'd0);
        chk("t6_rst_fill", 32'(fill_count), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        do_order(1'b1, 1'b1, 1);
        chk("t6_post_rst_pos", 32'(position), 32'd7);
        chk("t6_post_rst_fill", 32'(fill_count), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
